mvm3_input_streamer: RTL and testbench

- Transmitter for the matrix-vector multiplier input interface. It holds one MxM weight matrix and one M-vector in local buffers, loaded by a host write port.
- On a start command it streams the words to the multiplier over a valid/ready handshake. The matrix words are sent only when a new matrix is required; the vector words are always sent.
- It sits between the host/control logic and the multiplier's input_valid/input_ready/input_data/new_matrix port, so the multiplier can reuse its stored matrix across vectors.

---
 rtl/mvm3_pkg.sv | 21 ++
 rtl/mvm3_word_buf.sv | 37 +++
 rtl/mvm3_input_streamer.sv | 172 +++++++++++++++++
 tb/tb_mvm3_input_streamer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm3_pkg.sv
// Shared types and constants for the matrix-vector multiplier input streamer.
package mvm3_pkg;

  localparam int DEF_DW   = 14;
  localparam int DEF_M    = 3;
  localparam int MAT_BASE = 0;

  function automatic int vec_base(input int m);
    return m * m;
  endfunction

  localparam int VEC_BASE = vec_base(DEF_M);

  typedef enum logic [1:0] {
    IDLE,
    SEND_MAT,
    SEND_VEC,
    DONE
  } state_e;

endpackage

// File: rtl/mvm3_word_buf.sv
// Register-file word buffer: one write port, one asynchronous read port,
// synchronous active-low clear.
module mvm3_word_buf #(
  parameter int DW    = 14,
  parameter int DEPTH = 12,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic signed [DW-1:0] wr_data,
  input  logic [AW-1:0]        rd_addr,
  output logic signed [DW-1:0] rd_data
);

  logic signed [DW-1:0] mem_q [DEPTH];
  logic signed [DW-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en && (int'(wr_addr) < DEPTH)) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = (int'(rd_addr) < DEPTH) ? mem_q[rd_addr] : '0;

endmodule

// File: rtl/mvm3_input_streamer.sv
// Streams a buffered MxM matrix (only when needed) and M-vector to the
// multiplier over valid/ready, marking the first word of each job.
module mvm3_input_streamer
  import mvm3_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int M  = DEF_M,
  parameter int AW = $clog2(M*M+M)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic signed [DW-1:0] wr_data,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic                 start_new_matrix,
  output logic                 mvm_valid,
  input  logic                 mvm_ready,
  output logic signed [DW-1:0] mvm_data,
  output logic                 mvm_new_matrix,
  output logic                 busy,
  output logic                 done,
  output logic                 wr_err
);

  localparam int MatWords = M * M;
  localparam int BufWords = M * M + M;
  localparam int VecBase  = vec_base(M);
  localparam int CW       = $clog2(M * M);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 need_matrix_q, need_matrix_d;
  logic                 valid_q, valid_d;
  logic signed [DW-1:0] data_q, data_d;
  logic                 new_q, new_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wr_err_q, wr_err_d;

  logic                 wr_ok, mat_wr, eff_new, xfer, load_word;
  logic [AW-1:0]        rd_addr;
  logic signed [DW-1:0] rd_data;

  mvm3_word_buf #(
    .DW    (DW),
    .DEPTH (BufWords),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    need_matrix_d = need_matrix_q;
    valid_d       = valid_q;
    data_d        = data_q;
    new_d         = new_q;
    done_d        = 1'b0;
    wr_err_d      = 1'b0;
    rd_addr       = '0;
    load_word     = 1'b0;

    wr_ok   = wr_en && (state_q == IDLE) && (int'(wr_addr) < BufWords);
    mat_wr  = wr_ok && (int'(wr_addr) < VecBase);
    eff_new = start_new_matrix | need_matrix_q | mat_wr;
    xfer    = valid_q && mvm_ready;

    if (wr_en && !wr_ok) wr_err_d = 1'b1;
    if (mat_wr) need_matrix_d = 1'b1;

    // rd_addr always points at the word to present after this edge
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          cnt_d     = '0;
          load_word = 1'b1;
          new_d     = eff_new;
          if (eff_new) begin
            state_d = SEND_MAT;
            rd_addr = AW'(MAT_BASE);
          end else begin
            state_d = SEND_VEC;
            rd_addr = AW'(VecBase);
          end
        end
      end
      SEND_MAT: begin
        if (xfer) begin
          load_word = 1'b1;
          new_d     = 1'b0;
          if (cnt_q == CW'(MatWords - 1)) begin
            state_d       = SEND_VEC;
            cnt_d         = '0;
            need_matrix_d = 1'b0;
            rd_addr       = AW'(VecBase);
          end else begin
            cnt_d   = cnt_q + CW'(1);
            rd_addr = AW'(MAT_BASE) + AW'(cnt_q) + AW'(1);
          end
        end
      end
      SEND_VEC: begin
        if (xfer) begin
          new_d = 1'b0;
          if (cnt_q == CW'(M - 1)) begin
            state_d = DONE;
            cnt_d   = '0;
            valid_d = 1'b0;
            data_d  = '0;
            done_d  = 1'b1;
          end else begin
            load_word = 1'b1;
            cnt_d     = cnt_q + CW'(1);
            rd_addr   = AW'(VecBase) + AW'(cnt_q) + AW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // a write landing at the same edge as start belongs to the job
    if (load_word) begin
      valid_d = 1'b1;
      data_d  = (wr_ok && (wr_addr == rd_addr)) ? wr_data : rd_data;
    end

    busy_d = (state_d == SEND_MAT) || (state_d == SEND_VEC);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      need_matrix_q <= 1'b1;
      valid_q       <= 1'b0;
      data_q        <= '0;
      new_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      need_matrix_q <= need_matrix_d;
      valid_q       <= valid_d;
      data_q        <= data_d;
      new_q         <= new_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      wr_err_q      <= wr_err_d;
    end
  end

  assign start_ready    = (state_q == IDLE);
  assign mvm_valid      = valid_q;
  assign mvm_data       = data_q;
  assign mvm_new_matrix = new_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign wr_err         = wr_err_q;

endmodule

// File: tb/tb_mvm3_input_streamer.sv
// Self-checking bench: job-level queue model of the streamer plus literal checks.
module tb_mvm3_input_streamer;
  import mvm3_pkg::*;

  localparam int DW = DEF_DW;
  localparam int M  = DEF_M;
  localparam int NW = M * M + M;
  localparam int AW = $clog2(NW);

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 wr_en = 1'b0;
  logic [AW-1:0]        wr_addr = '0;
  logic signed [DW-1:0] wr_data = '0;
  logic                 start_valid = 1'b0;
  logic                 start_ready;
  logic                 start_new_matrix = 1'b0;
  logic                 mvm_valid;
  logic                 mvm_ready = 1'b1;
  logic signed [DW-1:0] mvm_data;
  logic                 mvm_new_matrix;
  logic                 busy;
  logic                 done;
  logic                 wr_err;

  always #5 clk = ~clk;

  mvm3_input_streamer #(
    .DW (DW),
    .M  (M),
    .AW (AW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .start_valid      (start_valid),
    .start_ready      (start_ready),
    .start_new_matrix (start_new_matrix),
    .mvm_valid        (mvm_valid),
    .mvm_ready        (mvm_ready),
    .mvm_data         (mvm_data),
    .mvm_new_matrix   (mvm_new_matrix),
    .busy             (busy),
    .done             (done),
    .wr_err           (wr_err)
  );

  int errors = 0;
  int checks = 0;

  // Model: buffer image, need flag, queue of words the current job still owes.
  int mbuf [NW];
  bit need = 1'b1;
  int q_data [$];
  bit q_new  [$];
  bit done_now = 1'b0;
  bit err_now  = 1'b0;
  bit held_v = 1'b0;
  int held_d = 0;
  bit held_n = 1'b0;
  bit rand_ready = 1'b0;
  int cap  [$];
  bit capn [$];

  int s1 [12] = '{10, -20, 30, 50, -60, 70, 80, 100, -110, 40, 30, -20};
  int y_exp [3] = '{-400, 1200, 5700};

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Check this cycle's outputs, then advance the model across the coming edge.
  task automatic model_step();
    bit idle;
    bit matw;
    bit eff;
    if (!reset) begin
      q_data.delete();
      q_new.delete();
      foreach (mbuf[i]) mbuf[i] = 0;
      need = 1'b1; done_now = 1'b0; err_now = 1'b0; held_v = 1'b0;
      return;
    end
    chk("valid",       32'(mvm_valid),   32'(q_data.size() > 0));
    chk("busy",        32'(busy),        32'(q_data.size() > 0));
    chk("done",        32'(done),        32'(done_now));
    chk("start_ready", 32'(start_ready), 32'((q_data.size() == 0) && !done_now));
    chk("wr_err",      32'(wr_err),      32'(err_now));
    if (q_data.size() > 0) begin
      chk("data",       32'(mvm_data),       q_data[0]);
      chk("new_matrix", 32'(mvm_new_matrix), 32'(q_new[0]));
    end else begin
      chk("idle_data", 32'(mvm_data), 0);
    end
    if (held_v) begin
      chk("stall_data", 32'(mvm_data),       held_d);
      chk("stall_new",  32'(mvm_new_matrix), 32'(held_n));
    end
    held_v = mvm_valid && !mvm_ready;
    held_d = int'(mvm_data);
    held_n = mvm_new_matrix;

    idle = (q_data.size() == 0) && !done_now;
    done_now = 1'b0; err_now = 1'b0; matw = 1'b0;
    if (wr_en) begin
      if (idle && (int'(wr_addr) < NW)) begin
        mbuf[wr_addr] = int'(wr_data);
        if (int'(wr_addr) < M * M) begin need = 1'b1; matw = 1'b1; end
      end else begin
        err_now = 1'b1;
      end
    end
    if ((q_data.size() > 0) && mvm_ready) begin
      cap.push_back(int'(mvm_data));
      capn.push_back(mvm_new_matrix);
      void'(q_data.pop_front());
      void'(q_new.pop_front());
      if (q_data.size() == 0) done_now = 1'b1;
    end
    if (idle && start_valid) begin
      eff = start_new_matrix | need | matw;
      if (eff) begin
        for (int i = 0; i < M * M; i++) begin
          q_data.push_back(mbuf[i]);
          q_new.push_back(i == 0);
        end
        need = 1'b0;
      end
      for (int j = 0; j < M; j++) begin
        q_data.push_back(mbuf[VEC_BASE + j]);
        q_new.push_back(1'b0);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    if (rand_ready) mvm_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic write(input int a, input int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_finish(input int budget);
    int n = 0;
    while (((q_data.size() > 0) || done_now) && (n < budget)) begin
      tick();
      n++;
    end
  endtask

  task automatic run_job(input bit snm, input int budget);
    cap.delete(); capn.delete();
    start_valid = 1'b1; start_new_matrix = snm;
    tick();
    start_valid = 1'b0; start_new_matrix = 1'b0;
    wait_finish(budget);
  endtask

  task automatic check_cap_s1(input string tag);
    chk({tag, "_len"}, cap.size(), 12);
    for (int i = 0; i < 12 && i < cap.size(); i++) chk({tag, "_word"}, cap[i], s1[i]);
    if (capn.size() > 0) chk({tag, "_first_new"}, 32'(capn[0]), 1);
  endtask

  initial begin
    int y;
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // Scenario 1: fresh load, need_matrix forces matrix send.
    for (int i = 0; i < 12; i++) write(i, s1[i]);
    run_job(1'b0, 60);
    check_cap_s1("first_job");

    // Scenario 2: vector-only reuse, product against literal results.
    write(9, 50); write(10, -60); write(11, -70);
    run_job(1'b0, 40);
    chk("reuse_len", cap.size(), 3);
    if (cap.size() == 3) begin
      chk("reuse_v0", cap[0], 50);
      chk("reuse_v1", cap[1], -60);
      chk("reuse_v2", cap[2], -70);
      chk("reuse_new", 32'(capn[0]), 0);
      for (int r = 0; r < 3; r++) begin
        y = 0;
        for (int c = 0; c < 3; c++) y += s1[r * 3 + c] * cap[c];
        chk("mult_out", y, y_exp[r]);
      end
    end

    // Scenario 3: random backpressure, same sequence as the first job.
    write(9, 40); write(10, 30); write(11, -20);
    rand_ready = 1'b1;
    run_job(1'b1, 300);
    rand_ready = 1'b0; mvm_ready = 1'b1;
    check_cap_s1("backpressure");

    // Scenario 4: matrix dirty after a reuse job.
    run_job(1'b0, 40);
    chk("reuse2_len", cap.size(), 3);
    write(4, 123);
    run_job(1'b0, 60);
    chk("dirty_len", cap.size(), 12);
    if (cap.size() == 12) begin
      chk("dirty_word4", cap[4], 123);
      chk("dirty_new", 32'(capn[0]), 1);
    end

    // Scenario 5: writes and start while busy, out-of-range write while idle.
    mvm_ready = 1'b0;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    write(9, 777);
    write(0, 555);
    start_valid = 1'b1; start_new_matrix = 1'b1;
    tick();
    start_valid = 1'b0; start_new_matrix = 1'b0;
    tick();
    mvm_ready = 1'b1;
    wait_finish(40);
    write(12, 999);
    run_job(1'b1, 60);
    chk("protect_len", cap.size(), 12);
    if (cap.size() == 12) begin
      chk("protect_m0", cap[0], 10);
      chk("protect_v0", cap[9], 40);
    end

    // Scenario 6: reset after five matrix transfers.
    cap.delete(); capn.delete();
    start_valid = 1'b1; start_new_matrix = 1'b1;
    tick();
    start_valid = 1'b0; start_new_matrix = 1'b0;
    for (int n = 0; n < 40 && cap.size() < 5; n++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #2;
    chk("reset_valid", 32'(mvm_valid), 0);
    chk("reset_ready", 32'(start_ready), 1);
    run_job(1'b0, 60);
    chk("post_reset_len", cap.size(), 12);
    for (int i = 0; i < cap.size(); i++) chk("post_reset_zero", cap[i], 0);
    if (capn.size() > 0) chk("post_reset_new", 32'(capn[0]), 1);

    // Randomised jobs: random writes (some out of range or mid-job), ready, flags.
    for (int it = 0; it < 30; it++) begin
      int nw;
      nw = int'($urandom_range(0, 3));
      for (int k = 0; k < nw; k++) write(int'($urandom_range(0, 15)), int'($urandom));
      rand_ready = 1'($urandom_range(0, 1));
      if (!rand_ready) mvm_ready = 1'b1;
      start_valid = 1'b1;
      start_new_matrix = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        wr_en = 1'b1;
        wr_addr = AW'($urandom_range(0, 11));
        wr_data = DW'($urandom);
      end
      tick();
      start_valid = 1'b0; start_new_matrix = 1'b0; wr_en = 1'b0;
      if ($urandom_range(0, 2) == 0) write(int'($urandom_range(0, 15)), int'($urandom));
      wait_finish(300);
      tick();
    end
    rand_ready = 1'b0;
    mvm_ready = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
